// File: rtl/ex_hazard_fwd_ctrl_pkg.sv
// Shared types for the EX-stage forwarding and hazard controller.
// Pipe tags shadow just enough of each in-flight instruction to detect RAW hazards.
package ex_hazard_fwd_ctrl_pkg;

  localparam int TAG_AW = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_WB   = 2'd1,
    FWD_MEM  = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_LU_STALL = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rd;
    logic              regwrite;
    logic              is_load;
  } pipe_tag_t;

  // x0 is hardwired to zero, so a write to it never produces a forwardable value
  function automatic logic tag_writes(input pipe_tag_t t, input logic [TAG_AW-1:0] rs);
    return t.valid && t.regwrite && (t.rd != '0) && (t.rd == rs);
  endfunction

endpackage

// File: rtl/ex_hazard_fwd_ctrl_fwd_cmp.sv
// Forward-select comparator for one source operand against the two older producers.
// The producer that will sit in MEM is younger than the one in WB, so it wins.
module ex_hazard_fwd_ctrl_fwd_cmp
  import ex_hazard_fwd_ctrl_pkg::*;
(
  input  logic [TAG_AW-1:0] rs_i,
  input  logic              used_i,
  input  pipe_tag_t         mem_tag_i,
  input  pipe_tag_t         wb_tag_i,
  output fwd_sel_t          sel_o
);

  always_comb begin
    sel_o = FWD_NONE;
    if (used_i) begin
      if (tag_writes(mem_tag_i, rs_i)) begin
        sel_o = FWD_MEM;
      end else if (tag_writes(wb_tag_i, rs_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/ex_hazard_fwd_ctrl.sv
// EX-stage forwarding selects plus load-use stall, bubble and branch-flush control.
// Selects are registered at each ID->EX advance and stay stable for the EX occupancy.
module ex_hazard_fwd_ctrl
  import ex_hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_AW   = TAG_AW,
  parameter int FWD_W    = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_op1_is_reg_i,
  input  logic              id_op2_is_reg_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_is_load_i,
  input  logic              br_taken_i,
  input  logic              mem_stall_i,
  output logic [FWD_W-1:0]  ex_fwd_sel1_o,
  output logic [FWD_W-1:0]  ex_fwd_sel2_o,
  output logic              stall_if_id_o,
  output logic              bubble_ex_o,
  output logic              flush_if_id_o
);

  localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  hz_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  pipe_tag_t         exSlot_q, exSlot_d;
  pipe_tag_t         memSlot_q, memSlot_d;
  fwd_sel_t          sel1_q, sel1_d, sel2_q, sel2_d;
  fwd_sel_t          cmpSel1, cmpSel2;
  logic [TAG_AW-1:0] rs1, rs2;
  logic              loadUse;
  pipe_tag_t         idTag;

  assign rs1 = TAG_AW'(id_rs1_i);
  assign rs2 = TAG_AW'(id_rs2_i);

  assign idTag = '{valid:    id_valid_i,
                   rd:       TAG_AW'(id_rd_i),
                   regwrite: id_regwrite_i,
                   is_load:  id_is_load_i};

  // The EX producer reaches MEM after this advance; the MEM producer reaches WB
  ex_hazard_fwd_ctrl_fwd_cmp u_cmp1 (
    .rs_i      (rs1),
    .used_i    (id_valid_i && id_op1_is_reg_i),
    .mem_tag_i (exSlot_q),
    .wb_tag_i  (memSlot_q),
    .sel_o     (cmpSel1)
  );

  ex_hazard_fwd_ctrl_fwd_cmp u_cmp2 (
    .rs_i      (rs2),
    .used_i    (id_valid_i && id_op2_is_reg_i),
    .mem_tag_i (exSlot_q),
    .wb_tag_i  (memSlot_q),
    .sel_o     (cmpSel2)
  );

  // Both rs fields are compared regardless of operand muxing: stores and branches read rs2 too
  assign loadUse = id_valid_i && exSlot_q.valid && exSlot_q.is_load &&
                   (exSlot_q.rd != '0) && ((exSlot_q.rd == rs1) || (exSlot_q.rd == rs2));

  always_comb begin
    stall_if_id_o = 1'b0;
    bubble_ex_o   = 1'b0;
    flush_if_id_o = 1'b0;
    if (mem_stall_i) begin
      stall_if_id_o = 1'b1;
    end else if (br_taken_i) begin
      flush_if_id_o = 1'b1;
      bubble_ex_o   = 1'b1;
    end else if ((state_q == HZ_LU_STALL) || loadUse) begin
      stall_if_id_o = 1'b1;
      bubble_ex_o   = 1'b1;
    end
  end

  // The detecting cycle is itself the first stall cycle, so LU_STALL only covers the rest
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exSlot_d  = exSlot_q;
    memSlot_d = memSlot_q;
    sel1_d    = sel1_q;
    sel2_d    = sel2_q;
    if (!mem_stall_i) begin
      if (br_taken_i) begin
        state_d = HZ_RUN;
        cnt_d   = '0;
      end else if (state_q == HZ_LU_STALL) begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = HZ_RUN;
        end
      end else if (loadUse) begin
        cnt_d   = CNT_W'(LOAD_LAT - 1);
        state_d = (LOAD_LAT > 1) ? HZ_LU_STALL : HZ_RUN;
      end

      memSlot_d = exSlot_q;
      if (bubble_ex_o) begin
        exSlot_d = '0;
        sel1_d   = FWD_NONE;
        sel2_d   = FWD_NONE;
      end else begin
        exSlot_d = idTag;
        sel1_d   = cmpSel1;
        sel2_d   = cmpSel2;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= HZ_RUN;
      cnt_q     <= '0;
      exSlot_q  <= '0;
      memSlot_q <= '0;
      sel1_q    <= FWD_NONE;
      sel2_q    <= FWD_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exSlot_q  <= exSlot_d;
      memSlot_q <= memSlot_d;
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
    end
  end

  assign ex_fwd_sel1_o = FWD_W'(sel1_q);
  assign ex_fwd_sel2_o = FWD_W'(sel2_q);

endmodule
